// File: rtl/fft_bfly_per_if.sv
`default_nettype none
// ============================================================================
// Module      : fft_bfly_per_if
// Description : openMSP430 peripheral bus bundle (address, data, enables,
//               read-back data) shared by the CPU side and a peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
interface fft_bfly_per_if;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;

    modport master (
        output per_addr, per_din, per_en, per_we,
        input  per_dout
    );

    modport slave (
        input  per_addr, per_din, per_en, per_we,
        output per_dout
    );
endinterface
`default_nettype wire

// File: rtl/fft_bfly_per.sv
`default_nettype none
// ============================================================================
// Module      : fft_bfly_per
// Description : Memory-mapped radix-2 DIT butterfly coprocessor.
//               X = A + W*B, Y = A - W*B on signed Q15 complex operands,
//               using one shared 16x16 multiplier over four cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_bfly_per #(
    parameter logic [14:0] BASE_ADDR = 15'h01A0
) (
    input  wire logic     mclk,
    input  wire logic     reset_n,
    fft_bfly_per_if.slave per
);

    // Register indices (word offsets inside the 32-byte window)
    localparam logic [3:0] c_IDX_CTRL = 4'd6;
    localparam int         c_AR = 0;
    localparam int         c_AI = 1;
    localparam int         c_BR = 2;
    localparam int         c_BI = 3;
    localparam int         c_WR = 4;
    localparam int         c_WI = 5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_M0   = 3'd1,
        S_M1   = 3'd2,
        S_M2   = 3'd3,
        S_M3   = 3'd4,
        S_WB   = 3'd5
    } state_t;

    state_t             r_state;
    logic [15:0]        r_op [0:5];
    logic               r_scale;
    logic               r_ovf;
    logic               r_done;
    logic signed [32:0] r_acc;
    logic [15:0]        r_tr;
    logic [15:0]        r_ti;
    logic [15:0]        r_res [0:3];

    logic               w_sel;
    logic [3:0]         w_idx;
    logic               w_busy;
    logic               w_op_wr;
    logic               w_ctrl_wr;
    logic               w_start;
    logic               w_ovf_clr;
    logic               w_ovf_set;
    logic signed [15:0] w_mul_a;
    logic signed [15:0] w_mul_b;
    logic signed [31:0] w_prod;
    logic signed [32:0] w_prod_ext;
    logic signed [32:0] w_acc_next;
    logic signed [33:0] w_rnd;
    logic [18:0]        w_t_full;
    logic               w_t_clip;
    logic [15:0]        w_t_sat;
    logic [16:0]        w_sum [0:3];
    logic [16:0]        w_fin [0:3];
    logic               w_wb_clip;
    logic [15:0]        w_rdata;
    logic               w_unused;

    // Bus decode: 16 words starting at the 32-byte aligned base
    assign w_sel     = per.per_en & (per.per_addr[13:4] == BASE_ADDR[14:5]);
    assign w_idx     = per.per_addr[3:0];
    assign w_busy    = (r_state != S_IDLE);
    assign w_op_wr   = w_sel & (|per.per_we) & ~w_busy;
    assign w_ctrl_wr = w_sel & per.per_we[0] & (w_idx == c_IDX_CTRL);
    assign w_start   = w_ctrl_wr & per.per_din[0];
    assign w_ovf_clr = w_ctrl_wr & per.per_din[2];

    // Multiplier operand selection for the four product steps
    always_comb begin
        w_mul_a = r_op[c_WR];
        w_mul_b = r_op[c_BR];
        case (r_state)
            S_M1: begin w_mul_a = r_op[c_WI]; w_mul_b = r_op[c_BI]; end
            S_M2: begin w_mul_a = r_op[c_WR]; w_mul_b = r_op[c_BI]; end
            S_M3: begin w_mul_a = r_op[c_WI]; w_mul_b = r_op[c_BR]; end
            default: ;
        endcase
    end

    assign w_prod     = w_mul_a * w_mul_b;
    assign w_prod_ext = {w_prod[31], w_prod};

    // Accumulator update: load on M0/M2, subtract on M1, add on M3
    always_comb begin
        case (r_state)
            S_M0:    w_acc_next = w_prod_ext;
            S_M1:    w_acc_next = r_acc - w_prod_ext;
            S_M2:    w_acc_next = w_prod_ext;
            S_M3:    w_acc_next = r_acc + w_prod_ext;
            default: w_acc_next = r_acc;
        endcase
    end

    // Round-half-up to Q15, then clip the 19-bit quotient to 16 bits
    assign w_rnd    = {w_acc_next[32], w_acc_next} + 34'sd16384;
    assign w_t_full = w_rnd[33:15];
    assign w_t_clip = ~((&w_t_full[18:15]) | ~(|w_t_full[18:15]));
    assign w_t_sat  = w_t_clip ? (w_t_full[18] ? 16'h8000 : 16'h7FFF) : w_t_full[15:0];

    assign w_unused = &{1'b0, w_rnd[14:0]};

    // Scale-or-saturate a 17-bit sum; returns {clip, result}
    function automatic logic [16:0] f_finish(input logic [16:0] s, input logic scale);
        if (scale)
            return {1'b0, s[16:1]};
        else if (s[16] != s[15])
            return {1'b1, (s[16] ? 16'h8000 : 16'h7FFF)};
        else
            return {1'b0, s[15:0]};
    endfunction

    // Butterfly sums/differences at 17 bits, then final scaling/saturation
    always_comb begin
        w_sum[0] = {r_op[c_AR][15], r_op[c_AR]} + {r_tr[15], r_tr};
        w_sum[1] = {r_op[c_AI][15], r_op[c_AI]} + {r_ti[15], r_ti};
        w_sum[2] = {r_op[c_AR][15], r_op[c_AR]} - {r_tr[15], r_tr};
        w_sum[3] = {r_op[c_AI][15], r_op[c_AI]} - {r_ti[15], r_ti};
        w_wb_clip = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_fin[i]  = f_finish(w_sum[i], r_scale);
            w_wb_clip = w_wb_clip | w_fin[i][16];
        end
    end

    assign w_ovf_set = (((r_state == S_M1) || (r_state == S_M3)) & w_t_clip) |
                       ((r_state == S_WB) & w_wb_clip);

    // Operand and SCALE registers: byte-writable, frozen while busy
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 6; i++) r_op[i] <= 16'h0000;
            r_scale <= 1'b0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (w_op_wr && (w_idx == 4'(i))) begin
                    if (per.per_we[0]) r_op[i][7:0]  <= per.per_din[7:0];
                    if (per.per_we[1]) r_op[i][15:8] <= per.per_din[15:8];
                end
            end
            if (w_ctrl_wr && !w_busy) r_scale <= per.per_din[1];
        end
    end

    // Sequencer with accumulator, T latches, results and status flags
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_acc   <= 33'sd0;
            r_tr    <= 16'h0000;
            r_ti    <= 16'h0000;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            for (int i = 0; i < 4; i++) r_res[i] <= 16'h0000;
        end else begin
            r_acc <= w_acc_next;
            // set wins over a coincident clear
            r_ovf <= (r_ovf & ~w_ovf_clr) | w_ovf_set;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_M0;
                        r_done  <= 1'b0;
                    end
                end
                S_M0: r_state <= S_M1;
                S_M1: begin
                    r_state <= S_M2;
                    r_tr    <= w_t_sat;
                end
                S_M2: r_state <= S_M3;
                S_M3: begin
                    r_state <= S_WB;
                    r_ti    <= w_t_sat;
                end
                S_WB: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                    for (int i = 0; i < 4; i++) r_res[i] <= w_fin[i][15:0];
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Combinational read-back, zero when not selected (OR-ed bus)
    always_comb begin
        w_rdata = 16'h0000;
        case (w_idx)
            4'd0:    w_rdata = r_op[0];
            4'd1:    w_rdata = r_op[1];
            4'd2:    w_rdata = r_op[2];
            4'd3:    w_rdata = r_op[3];
            4'd4:    w_rdata = r_op[4];
            4'd5:    w_rdata = r_op[5];
            4'd6:    w_rdata = {12'h000, r_done, r_ovf, r_scale, w_busy};
            4'd7:    w_rdata = r_res[0];
            4'd8:    w_rdata = r_res[1];
            4'd9:    w_rdata = r_res[2];
            4'd10:   w_rdata = r_res[3];
            default: w_rdata = 16'h0000;
        endcase
    end

    assign per.per_dout = w_sel ? w_rdata : 16'h0000;

endmodule
`default_nettype wire

// File: tb/tb_fft_bfly_per.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fft_bfly_per
// Description : Scoreboard bench for fft_bfly_per. Every bus probe pushes its
//               expected read value; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_bfly_per;

    localparam logic [13:0] c_BASE = 14'h00D0;   // word address of 0x01A0

    logic mclk    = 1'b0;
    logic reset_n = 1'b0;
    logic probe   = 1'b0;

    fft_bfly_per_if bus ();

    fft_bfly_per #(.BASE_ADDR(15'h01A0)) dut (
        .mclk    (mclk),
        .reset_n (reset_n),
        .per     (bus.slave)
    );

    always #5 mclk = ~mclk;

    logic [15:0] q_val [$];
    string       q_name [$];
    int          n_vec = 0;
    int          n_bad = 0;

    // Reference model state
    logic [15:0] m_op [6];
    logic [15:0] m_res [4];
    logic        m_scale;
    logic        m_ovf;
    logic        m_done;

    // Monitor: compare DUT read data with the oldest expectation
    always @(negedge mclk) begin
        if (probe) begin
            n_vec++;
            if (q_val.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_probe actual=%h required=<none>", bus.per_dout);
            end else begin
                logic [15:0] ev;
                string       en;
                ev = q_val.pop_front();
                en = q_name.pop_front();
                if (bus.per_dout !== ev) begin
                    n_bad++;
                    $display("FAIL %s actual=%h required=%h", en, bus.per_dout, ev);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic bit clips(input longint v);
        return (v > 32767) || (v < -32768);
    endfunction

    function automatic longint sat(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Butterfly from its arithmetic definition
    task automatic model_run();
        longint ar, ai, br, bi, wr, wi, tr, ti;
        longint s [4];
        ar = longint'($signed(m_op[0])); ai = longint'($signed(m_op[1]));
        br = longint'($signed(m_op[2])); bi = longint'($signed(m_op[3]));
        wr = longint'($signed(m_op[4])); wi = longint'($signed(m_op[5]));
        tr = (wr * br - wi * bi + 16384) >>> 15;
        ti = (wr * bi + wi * br + 16384) >>> 15;
        if (clips(tr) || clips(ti)) m_ovf = 1'b1;
        tr = sat(tr);
        ti = sat(ti);
        s[0] = ar + tr; s[1] = ai + ti; s[2] = ar - tr; s[3] = ai - ti;
        for (int i = 0; i < 4; i++) begin
            if (m_scale) begin
                m_res[i] = 16'(s[i] >>> 1);
            end else begin
                if (clips(s[i])) m_ovf = 1'b1;
                m_res[i] = 16'(sat(s[i]));
            end
        end
        m_done = 1'b1;
    endtask

    function automatic logic [15:0] ctrl_exp(input logic busy);
        return {12'h000, m_done, m_ovf, m_scale, busy};
    endfunction

    // One bus cycle; called and returning at posedge+1
    task automatic drive(input logic [13:0] a, input logic [15:0] d,
                         input logic [1:0] we, input logic en);
        bus.per_addr = a; bus.per_din = d; bus.per_we = we; bus.per_en = en;
        @(posedge mclk); #1;
        bus.per_addr = '0; bus.per_din = '0; bus.per_we = '0; bus.per_en = 1'b0;
        probe = 1'b0;
    endtask

    task automatic idle();
        @(posedge mclk); #1;
    endtask

    task automatic wr(input int idx, input logic [15:0] d, input logic [1:0] we);
        drive(c_BASE + 14'(idx), d, we, 1'b1);
    endtask

    task automatic probe_raw(input logic [13:0] a, input logic en,
                             input logic [15:0] ev, input string nm);
        q_val.push_back(ev);
        q_name.push_back(nm);
        probe = 1'b1;
        drive(a, 16'h0000, 2'b00, en);
    endtask

    task automatic rd(input int idx, input logic [15:0] ev, input string nm);
        probe_raw(c_BASE + 14'(idx), 1'b1, ev, nm);
    endtask

    task automatic set_op(input int idx, input logic [15:0] v);
        m_op[idx] = v;
        wr(idx, v, 2'b11);
    endtask

    task automatic set_all(input logic [15:0] ar, ai, br, bi, wr_, wi);
        set_op(0, ar); set_op(1, ai); set_op(2, br);
        set_op(3, bi); set_op(4, wr_); set_op(5, wi);
    endtask

    task automatic start(input logic scale);
        m_scale = scale;
        m_done  = 1'b0;
        wr(6, {13'd0, 1'b0, scale, 1'b1}, 2'b01);
    endtask

    task automatic clear_ovf(input logic scale);
        m_scale = scale;
        m_ovf   = 1'b0;
        wr(6, {13'd0, 1'b1, scale, 1'b0}, 2'b01);
    endtask

    // Start, wait out the latency (optionally polling), update the model
    task automatic run(input logic scale, input logic poll);
        start(scale);
        for (int k = 0; k < 5; k++) begin
            if (poll) rd(6, ctrl_exp(1'b1), $sformatf("busy_poll%0d", k));
            else      idle();
        end
        model_run();
        rd(6, ctrl_exp(1'b0), "ctrl_done");
    endtask

    task automatic check_res(input string tag);
        for (int i = 0; i < 4; i++) rd(7 + i, m_res[i], $sformatf("%s_res%0d", tag, i));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_op[i] = 16'h0000;
        for (int i = 0; i < 4; i++) m_res[i] = 16'h0000;
        m_scale = 1'b0; m_ovf = 1'b0; m_done = 1'b0;
    endtask

    function automatic logic [15:0] pick();
        int r;
        r = int'($urandom_range(0, 7));
        case (r)
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'h0000;
            3:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        bus.per_addr = '0; bus.per_din = '0; bus.per_we = '0; bus.per_en = 1'b0;
        model_reset();
        repeat (3) @(posedge mclk);
        #1;
        reset_n = 1'b1;

        // Reset state of the whole window
        for (int i = 0; i < 16; i++) rd(i, 16'h0000, $sformatf("reset_reg%0d", i));

        // Identity-ish twiddle with BUSY polling
        set_all(16'h1000, 16'h0200, 16'h0800, 16'hFF00, 16'h7FFF, 16'h0000);
        run(1'b0, 1'b1);
        rd(7, 16'h1800, "id_xr"); rd(8, 16'h0100, "id_xi");
        rd(9, 16'h0800, "id_yr"); rd(10, 16'h0300, "id_yi");

        // -j twiddle
        set_all(16'h0000, 16'h0000, 16'h0100, 16'h0200, 16'h0000, 16'h8000);
        run(1'b0, 1'b0);
        rd(7, 16'h0200, "mj_xr"); rd(8, 16'hFF00, "mj_xi");
        rd(9, 16'hFE00, "mj_yr"); rd(10, 16'h0100, "mj_yi");

        // Saturation, then OVF clear and scaled rerun
        set_all(16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000);
        run(1'b0, 1'b0);
        rd(6, 16'h000C, "sat_ctrl");
        rd(7, 16'h7FFF, "sat_xr"); rd(9, 16'h0001, "sat_yr");
        clear_ovf(1'b0);
        rd(6, 16'h0008, "ovf_cleared");
        run(1'b1, 1'b0);
        rd(6, 16'h000A, "scale_ctrl");
        rd(7, 16'h7FFE, "scale_xr"); rd(9, 16'h0000, "scale_yr");

        // Busy protection: BR write and second START while running
        set_all(16'h1000, 16'h0200, 16'h0800, 16'hFF00, 16'h7FFF, 16'h0000);
        start(1'b0);                 // now in M0
        idle();                      // now in M1
        wr(2, 16'h1234, 2'b11);      // sampled leaving M1
        wr(6, 16'h0001, 2'b01);      // second START, sampled leaving M2
        idle();
        idle();
        model_run();
        rd(6, ctrl_exp(1'b0), "bp_ctrl");
        rd(2, 16'h0800, "bp_br");
        check_res("bp");
        for (int k = 0; k < 3; k++) rd(6, ctrl_exp(1'b0), $sformatf("bp_single%0d", k));

        // Asynchronous reset during M2
        set_all(16'h1234, 16'h4321, 16'h0555, 16'hF000, 16'h5A5A, 16'hA5A5);
        start(1'b1);
        idle();
        idle();                      // now in M2
        reset_n = 1'b0;
        model_reset();
        #2;
        for (int i = 0; i < 11; i++) rd(i, 16'h0000, $sformatf("midrst_reg%0d", i));
        reset_n = 1'b1;
        set_all(16'h0400, 16'hFC00, 16'h2000, 16'h1000, 16'h5A82, 16'hA57E);
        run(1'b0, 1'b0);
        check_res("post_rst");

        // Bus decode and byte writes
        set_op(0, 16'h1111);
        probe_raw(c_BASE, 1'b0, 16'h0000, "en_low");
        probe_raw(c_BASE + 14'd16, 1'b1, 16'h0000, "addr_above");
        probe_raw(c_BASE - 14'd16, 1'b1, 16'h0000, "addr_below");
        wr(0, 16'hABCD, 2'b01);
        m_op[0] = 16'h11CD;
        rd(0, 16'h11CD, "byte_lo");
        wr(0, 16'h5678, 2'b10);
        rd(0, 16'h56CD, "byte_hi");
        wr(12, 16'hFFFF, 2'b11);
        rd(12, 16'h0000, "unused_idx");

        // Randomised butterflies against the reference model
        for (int n = 0; n < 40; n++) begin
            logic sc;
            sc = 1'($urandom_range(0, 1));
            set_all(pick(), pick(), pick(), pick(), pick(), pick());
            run(sc, 1'b0);
            check_res($sformatf("rnd%0d", n));
            if ($urandom_range(0, 3) == 0) begin
                clear_ovf(sc);
                rd(6, ctrl_exp(1'b0), $sformatf("rnd%0d_clr", n));
            end
        end

        idle();
        idle();
        n_vec++;
        if (q_val.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_expectations actual=%0d required=0", q_val.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
